// File: rtl/conv33_window_if.sv
// Handshake bundle between the pixel source, the 3x3 window generator and the
// convolution calculator that consumes its windows.
interface conv33_window_if #(
   parameter int DATA_WIDTH = 8
);
   logic                         in_valid;
   logic                         in_ready;
   logic signed [DATA_WIDTH-1:0] in_data;
   logic                         win_valid;
   logic                         win_ready;
   logic signed [DATA_WIDTH-1:0] data_0_0;
   logic signed [DATA_WIDTH-1:0] data_0_1;
   logic signed [DATA_WIDTH-1:0] data_0_2;
   logic signed [DATA_WIDTH-1:0] data_1_0;
   logic signed [DATA_WIDTH-1:0] data_1_1;
   logic signed [DATA_WIDTH-1:0] data_1_2;
   logic signed [DATA_WIDTH-1:0] data_2_0;
   logic signed [DATA_WIDTH-1:0] data_2_1;
   logic signed [DATA_WIDTH-1:0] data_2_2;
   logic                         frame_done;

   modport master (
      output in_valid, in_data, win_ready,
      input  in_ready, win_valid, frame_done,
      input  data_0_0, data_0_1, data_0_2,
      input  data_1_0, data_1_1, data_1_2,
      input  data_2_0, data_2_1, data_2_2
   );

   modport slave (
      input  in_valid, in_data, win_ready,
      output in_ready, win_valid, frame_done,
      output data_0_0, data_0_1, data_0_2,
      output data_1_0, data_1_1, data_1_2,
      output data_2_0, data_2_1, data_2_2
   );
endinterface

// File: rtl/conv33_window.sv
// Streaming 3x3 sliding-window generator: two line buffers plus per-row
// column taps, emitting every fully populated window with a valid/ready pair.
module conv33_window #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_W      = 28,
   parameter int IMG_H      = 28
) (
   input logic           clk,
   input logic           rst_n,
   conv33_window_if.slave bus
);
   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);

   typedef logic signed [DATA_WIDTH-1:0] pix_t;

   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   pix_t             r_lb_a [IMG_W];
   pix_t             r_lb_b [IMG_W];
   pix_t             r_tap  [3][2];
   pix_t             r_win  [3][3];
   logic             r_win_valid;
   logic             r_frame_done;

   logic w_acc;
   logic w_emit;
   logic w_last_col;
   logic w_last_row;
   pix_t w_col [3];

   assign bus.in_ready = !r_win_valid || bus.win_ready;
   assign w_acc        = bus.in_valid && bus.in_ready;
   assign w_last_col   = (r_col == COL_W'(IMG_W - 1));
   assign w_last_row   = (r_row == ROW_W'(IMG_H - 1));
   assign w_emit       = w_acc && (r_row >= ROW_W'(2))
                               && (r_col >= COL_W'(2));

   // Column entering the window: oldest row, middle row, incoming pixel.
   assign w_col[0] = r_lb_b[r_col];
   assign w_col[1] = r_lb_a[r_col];
   assign w_col[2] = bus.in_data;

   always_ff @(posedge clk) begin
      if (w_acc) begin
         r_lb_b[r_col] <= w_col[1];
         r_lb_a[r_col] <= w_col[2];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col        <= '0;
         r_row        <= '0;
         r_win_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 2; j++) r_tap[i][j] <= '0;
            for (int j = 0; j < 3; j++) r_win[i][j] <= '0;
         end
      end else begin
         r_frame_done <= w_acc && w_last_col && w_last_row;
         if (w_acc) begin
            for (int i = 0; i < 3; i++) begin
               r_tap[i][0] <= r_tap[i][1];
               r_tap[i][1] <= w_col[i];
            end
            if (w_last_col) begin
               r_col <= '0;
               r_row <= w_last_row ? '0 : r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
         // A new window may replace a consumed one in the same cycle.
         if (w_emit) begin
            for (int i = 0; i < 3; i++) begin
               r_win[i][0] <= r_tap[i][0];
               r_win[i][1] <= r_tap[i][1];
               r_win[i][2] <= w_col[i];
            end
            r_win_valid <= 1'b1;
         end else if (bus.win_ready) begin
            r_win_valid <= 1'b0;
         end
      end
   end

   assign bus.win_valid  = r_win_valid;
   assign bus.frame_done = r_frame_done;
   assign bus.data_0_0   = r_win[0][0];
   assign bus.data_0_1   = r_win[0][1];
   assign bus.data_0_2   = r_win[0][2];
   assign bus.data_1_0   = r_win[1][0];
   assign bus.data_1_1   = r_win[1][1];
   assign bus.data_1_2   = r_win[1][2];
   assign bus.data_2_0   = r_win[2][0];
   assign bus.data_2_1   = r_win[2][1];
   assign bus.data_2_2   = r_win[2][2];
endmodule

// File: tb/tb_conv33_window.sv
// Randomized-bubble bench for conv33_window on a 4x4 image, checked against
// a window list built directly from the pixel image.
module tb_conv33_window;
   localparam int DW = 8;
   localparam int W  = 4;
   localparam int H  = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   conv33_window_if #(.DATA_WIDTH(DW)) bus ();

   conv33_window #(
      .DATA_WIDTH(DW),
      .IMG_W(W),
      .IMG_H(H)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   typedef struct {
      logic [71:0] w;
      bit          last;
   } exp_t;

   exp_t        exp_q[$];
   int          n_chk = 0;
   int          n_err = 0;
   int          n_win = 0;
   int          fd_cnt = 0;
   int          hold_cnt = 0;
   bit          bubbles = 1'b0;
   logic [71:0] first_w = '0;
   logic [71:0] last_w = '0;

   task automatic chk(input string tag, input logic [71:0] got,
                      input logic [71:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [71:0] pack_out();
      return {bus.data_0_0, bus.data_0_1, bus.data_0_2,
              bus.data_1_0, bus.data_1_1, bus.data_1_2,
              bus.data_2_0, bus.data_2_1, bus.data_2_2};
   endfunction

   logic [71:0] mon_g;
   exp_t        mon_e;
   always @(negedge clk) begin
      if (rst_n && bus.frame_done) fd_cnt++;
      if (rst_n && bus.win_valid && bus.win_ready) begin
         mon_g = pack_out();
         if (exp_q.size() == 0) begin
            chk("unexp_win", 72'(exp_q.size()), 72'd1);
         end else begin
            mon_e = exp_q.pop_front();
            chk("win", mon_g, mon_e.w);
            chk("frame_done", 72'(bus.frame_done), 72'(mon_e.last));
         end
         if (n_win == 0) first_w = mon_g;
         last_w = mon_g;
         n_win++;
      end
      if (rst_n && bus.win_valid && !bus.win_ready) begin
         chk("hold_in_ready", 72'(bus.in_ready), 72'd0);
         if (exp_q.size() > 0) chk("hold_win", pack_out(), exp_q[0].w);
      end
   end

   initial begin
      bus.win_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (hold_cnt > 0 && bus.win_valid) begin
            bus.win_ready = 1'b0;
            hold_cnt--;
         end else begin
            bus.win_ready = 1'b1;
         end
      end
   end

   task automatic send_pixel(input logic [7:0] px, input bit emit);
      int t = 0;
      if (bubbles && $urandom_range(0, 1) == 1) begin
         bus.in_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = px;
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         t++;
         if (t > 50) begin
            chk("accept_timeout", 72'(t), 72'd0);
            bus.in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (emit) chk("lat_d22", {63'd0, bus.win_valid, bus.data_2_2},
                    {63'd0, 1'b1, px});
   endtask

   task automatic send_frame(input int base, input bit expect_win,
                             input int npix);
      logic [7:0]  img [H][W];
      logic [71:0] w;
      exp_t        e;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            img[r][c] = 8'(base + r * W + c);
      if (expect_win) begin
         for (int r = 2; r < H; r++) begin
            for (int c = 2; c < W; c++) begin
               w = '0;
               for (int i = 0; i < 3; i++)
                  for (int j = 0; j < 3; j++)
                     w = {w[63:0], img[r-2+i][c-2+j]};
               e.w    = w;
               e.last = (r == H - 1) && (c == W - 1);
               exp_q.push_back(e);
            end
         end
      end
      for (int k = 0; k < npix; k++)
         send_pixel(img[k/W][k%W], (k / W >= 2) && (k % W >= 2));
   endtask

   task automatic drain(input string tag);
      int t = 0;
      while ((exp_q.size() > 0 || bus.win_valid) && t < 40) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk({tag, "_drain"}, 72'(exp_q.size()), 72'd0);
   endtask

   task automatic start_scn();
      n_win  = 0;
      fd_cnt = 0;
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_win_valid", 72'(bus.win_valid), 72'd0);
      chk("rst_frame_done", 72'(bus.frame_done), 72'd0);
      chk("rst_taps", pack_out(), 72'd0);
      chk("rst_in_ready", 72'(bus.in_ready), 72'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      start_scn();
      send_frame(0, 1'b1, 16);
      drain("ramp");
      chk("ramp_nwin", 72'(n_win), 72'd4);
      chk("ramp_first", first_w, {8'd0, 8'd1, 8'd2, 8'd4, 8'd5,
                                  8'd6, 8'd8, 8'd9, 8'd10});
      chk("ramp_last", last_w, {8'd5, 8'd6, 8'd7, 8'd9, 8'd10,
                                8'd11, 8'd13, 8'd14, 8'd15});
      chk("ramp_fd", 72'(fd_cnt), 72'd1);

      start_scn();
      hold_cnt = 3;
      send_frame(0, 1'b1, 16);
      drain("hold");
      chk("hold_nwin", 72'(n_win), 72'd4);
      chk("hold_used", 72'(hold_cnt), 72'd0);

      start_scn();
      bubbles = 1'b1;
      send_frame(0, 1'b1, 16);
      bubbles = 1'b0;
      drain("bubble");
      chk("bubble_nwin", 72'(n_win), 72'd4);

      start_scn();
      bubbles = 1'b1;
      send_frame(0, 1'b1, 16);
      send_frame(16, 1'b1, 16);
      bubbles = 1'b0;
      drain("b2b");
      chk("b2b_nwin", 72'(n_win), 72'd8);
      chk("b2b_fd", 72'(fd_cnt), 72'd2);
      chk("b2b_last_d00", 72'(last_w[71:64]), 72'd21);

      start_scn();
      send_frame(-128, 1'b1, 16);
      drain("neg");
      chk("neg_first_d22", 72'(first_w[7:0]), 72'(8'h8A));
      chk("neg_first_d00", 72'(first_w[71:64]), 72'(8'h80));

      start_scn();
      send_frame(0, 1'b0, 7);
      rst_n = 1'b0;
      #2;
      chk("mid_rst_valid", 72'(bus.win_valid), 72'd0);
      chk("mid_rst_taps", pack_out(), 72'd0);
      chk("mid_rst_nwin", 72'(n_win), 72'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_frame(0, 1'b1, 16);
      drain("rst");
      chk("rst_nwin", 72'(n_win), 72'd4);
      chk("rst_first", first_w, {8'd0, 8'd1, 8'd2, 8'd4, 8'd5,
                                 8'd6, 8'd8, 8'd9, 8'd10});
      chk("rst_fd", 72'(fd_cnt), 72'd1);

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
